// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ producers.
// Each grant lasts for at most BURST accepted beats. A grant is followed by one IDLE cycle in which the next owner is picked.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           ack,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DW-1:0]             fifo_data_in,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t          state_reg;
    logic [GW-1:0]   grant_id_reg;
    logic [GW-1:0]   last_owner_reg;
    logic [CW-1:0]   beat_cnt_reg;
    logic [GW-1:0]   owner_next;
    logic            owner_found;
    logic            owner_req;
    logic            accept;
    logic            last_beat;
    logic [DW-1:0]   slice [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_port
            assign slice[gi] = req_data[gi*DW +: DW];
            assign ack[gi]   = accept && (grant_id_reg == GW'(gi));
        end
    endgenerate

    // Rotating priority: scan upward from the slot after the previous owner.
    always_comb begin
        owner_next  = last_owner_reg;
        owner_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!owner_found && req[(int'(last_owner_reg) + k) % NREQ]) begin
                owner_found = 1'b1;
                owner_next  = GW'((int'(last_owner_reg) + k) % NREQ);
            end
        end
    end

    assign owner_req    = req[grant_id_reg];
    // Reset kills the write in the same cycle so that an abandoned burst never leaks a beat.
    assign accept       = !rst && (state_reg == ST_BURST) && owner_req && !fifo_full;
    assign last_beat    = (beat_cnt_reg == CW'(BURST - 1));
    assign fifo_wr      = accept;
    assign fifo_data_in = accept ? slice[grant_id_reg] : '0;
    assign grant_id     = grant_id_reg;
    assign busy         = (state_reg == ST_BURST);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_id_reg   <= '0;
            beat_cnt_reg   <= '0;
            last_owner_reg <= GW'(NREQ - 1);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        grant_id_reg <= owner_next;
                        beat_cnt_reg <= '0;
                        state_reg    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (!owner_req) begin
                        state_reg      <= ST_IDLE;
                        last_owner_reg <= grant_id_reg;
                    end else if (!fifo_full) begin
                        beat_cnt_reg <= beat_cnt_reg + CW'(1);
                        if (last_beat) begin
                            state_reg      <= ST_IDLE;
                            last_owner_reg <= grant_id_reg;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter. It runs directed scenarios and then a randomized run.
// The randomized run is checked against a transaction-level model of the grant rules.
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic                 clock = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic                 fifo_full;
    logic                 fifo_wr;
    logic [DW-1:0]        fifo_data_in;
    logic [1:0]           grant_id;
    logic                 busy;

    logic [DW-1:0]        pdata [NREQ];
    logic [NREQ-1:0]      s_ack;
    logic                 s_wr;
    logic [DW-1:0]        s_data;
    logic [1:0]           s_grant;
    logic                 s_busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clock        (clock),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    // Called at a negedge with the inputs already driven. It samples the outputs, clocks once, and advances the producer that was acked.
    task automatic tick();
        #1;
        s_ack   = ack;
        s_wr    = fifo_wr;
        s_data  = fifo_data_in;
        s_grant = grant_id;
        s_busy  = busy;
        if (s_wr)
            $display("write t=%0t owner=%0d ack=%b data=%02h", $time, s_grant, s_ack, s_data);
        @(posedge clock);
        for (int i = 0; i < NREQ; i++)
            if (s_ack[i]) pdata[i] = pdata[i] + 8'd1;
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; fifo_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; fifo_full = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL reset_wr c%0d: got %b want 0", c, s_wr); end
            checks++; if (s_ack !== 4'b0) begin errors++; $display("FAIL reset_ack c%0d: got %b want 0000", c, s_ack); end
            checks++; if (s_data !== 8'h00) begin errors++; $display("FAIL reset_data c%0d: got %h want 00", c, s_data); end
        end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL idle_wr c%0d: got %b want 0", c, s_wr); end
            checks++; if (s_ack !== 4'b0) begin errors++; $display("FAIL idle_ack c%0d: got %b want 0000", c, s_ack); end
            checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL idle_busy c%0d: got %b want 0", c, s_busy); end
            checks++; if (s_grant !== 2'd0) begin errors++; $display("FAIL idle_grant c%0d: got %0d want 0", c, s_grant); end
        end
    endtask

    task automatic test_single();
        int  wcount;
        bit  exp_wr;
        wcount = 0;
        do_reset();
        pdata[2] = 8'hA0;
        req = 4'b0100;
        for (int c = 0; c < 10; c++) begin
            exp_wr = (c % 5) != 0;
            tick();
            checks++; if (s_wr !== exp_wr) begin errors++; $display("FAIL single_wr c%0d: got %b want %b", c, s_wr, exp_wr); end
            if (exp_wr) begin
                checks++; if (s_data !== 8'(8'hA0 + wcount)) begin errors++; $display("FAIL single_data c%0d: got %h want %h", c, s_data, 8'(8'hA0 + wcount)); end
                checks++; if (s_ack !== 4'b0100) begin errors++; $display("FAIL single_ack c%0d: got %b want 0100", c, s_ack); end
                checks++; if (s_grant !== 2'd2) begin errors++; $display("FAIL single_grant c%0d: got %0d want 2", c, s_grant); end
                wcount++;
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int cnt [NREQ];
        int phase, owner;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            pdata[i] = 8'(i * 16);
            cnt[i]   = 0;
        end
        req = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            phase = c % 5;
            owner = (c / 5) % NREQ;
            tick();
            checks++; if (s_wr !== (phase != 0)) begin errors++; $display("FAIL rr_wr c%0d: got %b want %b", c, s_wr, phase != 0); end
            checks++; if (s_busy !== (phase != 0)) begin errors++; $display("FAIL rr_busy c%0d: got %b want %b", c, s_busy, phase != 0); end
            if (phase != 0) begin
                checks++; if (s_ack !== 4'(1 << owner)) begin errors++; $display("FAIL rr_ack c%0d: got %b want %b", c, s_ack, 4'(1 << owner)); end
                checks++; if (s_grant !== 2'(owner)) begin errors++; $display("FAIL rr_grant c%0d: got %0d want %0d", c, s_grant, owner); end
                checks++; if (s_data !== 8'(owner * 16 + cnt[owner])) begin errors++; $display("FAIL rr_data c%0d: got %h want %h", c, s_data, 8'(owner * 16 + cnt[owner])); end
                cnt[owner]++;
            end
        end
        req = '0;
        tick();
    endtask

    task automatic test_early_release();
        int acks1;
        logic [NREQ-1:0] rec_ack [6];
        logic            rec_wr  [6];
        logic            rec_busy[6];
        logic [1:0]      rec_grant[6];
        logic [DW-1:0]   rec_data[6];
        acks1 = 0;
        do_reset();
        pdata[1] = 8'h30;
        pdata[3] = 8'h70;
        for (int c = 0; c < 6; c++) begin
            req = {1'b1, 1'b0, acks1 < 2, 1'b0};
            tick();
            rec_ack[c] = s_ack; rec_wr[c] = s_wr; rec_busy[c] = s_busy;
            rec_grant[c] = s_grant; rec_data[c] = s_data;
            if (s_ack[1]) acks1++;
        end
        checks++; if (acks1 != 2) begin errors++; $display("FAIL early_count: got %0d writes want 2", acks1); end
        checks++; if (rec_ack[1] !== 4'b0010) begin errors++; $display("FAIL early_ack1: got %b want 0010", rec_ack[1]); end
        checks++; if (rec_ack[2] !== 4'b0010) begin errors++; $display("FAIL early_ack2: got %b want 0010", rec_ack[2]); end
        checks++; if (rec_wr[3] !== 1'b0 || rec_ack[3] !== 4'b0) begin errors++; $display("FAIL early_drop: got wr=%b ack=%b want 0/0000", rec_wr[3], rec_ack[3]); end
        checks++; if (rec_busy[4] !== 1'b0 || rec_wr[4] !== 1'b0) begin errors++; $display("FAIL early_idle: got busy=%b wr=%b want 0/0", rec_busy[4], rec_wr[4]); end
        checks++; if (rec_grant[5] !== 2'd3 || rec_ack[5] !== 4'b1000) begin errors++; $display("FAIL early_next: got grant=%0d ack=%b want 3/1000", rec_grant[5], rec_ack[5]); end
        checks++; if (rec_data[5] !== 8'h70) begin errors++; $display("FAIL early_data: got %h want 70", rec_data[5]); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_full_stall();
        int wr_total;
        bit exp_wr;
        wr_total = 0;
        do_reset();
        pdata[0] = 8'h50;
        req = 4'b0001;
        for (int c = 0; c < 9; c++) begin
            fifo_full = (c >= 2 && c <= 4);
            exp_wr = (c == 1) || (c >= 5 && c <= 7);
            tick();
            checks++; if (s_wr !== exp_wr) begin errors++; $display("FAIL stall_wr c%0d: got %b want %b", c, s_wr, exp_wr); end
            if (c >= 2 && c <= 4) begin
                checks++; if (s_ack !== 4'b0 || s_busy !== 1'b1) begin errors++; $display("FAIL stall_hold c%0d: got ack=%b busy=%b want 0000/1", c, s_ack, s_busy); end
            end
            if (s_wr) begin
                checks++; if (s_data !== 8'(8'h50 + wr_total)) begin errors++; $display("FAIL stall_data c%0d: got %h want %h", c, s_data, 8'(8'h50 + wr_total)); end
                wr_total++;
            end
        end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL stall_end_busy: got %b want 0", s_busy); end
        checks++; if (wr_total != BURST) begin errors++; $display("FAIL stall_total: got %0d beats want %0d", wr_total, BURST); end
        fifo_full = 1'b0;
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        pdata[0] = 8'h11;
        pdata[3] = 8'h33;
        req = 4'b1000;
        tick();
        tick();
        checks++; if (s_wr !== 1'b1 || s_ack !== 4'b1000) begin errors++; $display("FAIL rmb_first: got wr=%b ack=%b want 1/1000", s_wr, s_ack); end
        rst = 1'b1;
        tick();
        checks++; if (s_wr !== 1'b0 || s_ack !== 4'b0 || s_data !== 8'h00) begin errors++; $display("FAIL rmb_rstcycle: got wr=%b ack=%b data=%h want 0/0000/00", s_wr, s_ack, s_data); end
        rst = 1'b0;
        req = 4'b1111;
        tick();
        checks++; if (s_busy !== 1'b0 || s_grant !== 2'd0 || s_wr !== 1'b0) begin errors++; $display("FAIL rmb_idle: got busy=%b grant=%0d wr=%b want 0/0/0", s_busy, s_grant, s_wr); end
        tick();
        checks++; if (s_ack !== 4'b0001 || s_grant !== 2'd0 || s_data !== 8'h11) begin errors++; $display("FAIL rmb_next: got ack=%b grant=%0d data=%h want 0001/0/11", s_ack, s_grant, s_data); end
        req = '0;
    endtask

    // Model: an owner of -1 means no grant is held. A grant ends after BURST accepted beats or when its owner drops req.
    task automatic test_random();
        int m_owner, m_grant, m_last, m_beats;
        bit e_wr;
        logic [NREQ-1:0] e_ack;
        logic [DW-1:0]   e_data;
        do_reset();
        m_owner = -1; m_grant = 0; m_last = NREQ - 1; m_beats = 0;
        for (int c = 0; c < 300; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            fifo_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                pdata[i] = 8'($urandom);
            end
            e_wr   = !rst && (m_owner >= 0) && req[m_owner] && !fifo_full;
            e_ack  = e_wr ? 4'(1 << m_owner) : 4'b0;
            e_data = e_wr ? pdata[m_owner] : 8'h00;
            tick();
            checks++; if (s_wr !== e_wr) begin errors++; $display("FAIL rand_wr c%0d: got %b want %b", c, s_wr, e_wr); end
            checks++; if (s_ack !== e_ack) begin errors++; $display("FAIL rand_ack c%0d: got %b want %b", c, s_ack, e_ack); end
            checks++; if (s_busy !== (m_owner >= 0)) begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", c, s_busy, m_owner >= 0); end
            checks++; if (s_grant !== 2'(m_grant)) begin errors++; $display("FAIL rand_grant c%0d: got %0d want %0d", c, s_grant, m_grant); end
            if (e_wr || rst || m_owner < 0) begin
                checks++; if (s_data !== e_data) begin errors++; $display("FAIL rand_data c%0d: got %h want %h", c, s_data, e_data); end
            end
            if (rst) begin
                m_owner = -1; m_grant = 0; m_last = NREQ - 1; m_beats = 0;
            end else if (m_owner < 0) begin
                if (req != '0) begin
                    for (int k = 1; k <= NREQ; k++)
                        if (m_owner < 0 && req[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
                    m_grant = m_owner;
                    m_beats = 0;
                end
            end else if (!req[m_owner]) begin
                m_last = m_owner; m_owner = -1;
            end else if (!fifo_full) begin
                m_beats++;
                if (m_beats == BURST) begin m_last = m_owner; m_owner = -1; end
            end
        end
        rst = 1'b0;
        req = '0;
        fifo_full = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) pdata[i] = '0;
        @(negedge clock);
        test_reset();
        test_single();
        test_round_robin();
        test_early_release();
        test_full_stall();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
